pipe_ctrl_gen: RTL and testbench
================================

PIPE_CTRL_GEN -- requirements
Module: pipe_ctrl_gen

Interface
Parameters:
REQ-001 The block SHALL have parameter MEM_STAGES, default 1, giving the number of memory pipeline stages (legal 1..4).
REQ-002 The block SHALL have parameter MULDIV_LAT, default 4, giving the multiply/divide occupancy in cycles (legal 1..15).

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have the following ports:
- clk  in  1  single clock; one clock, reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- opcode  in  6  decode-stage opcode.
- funct  in  6  decode-stage funct.
- zero  in  1  comparator result for the decode-stage branch.
- stall  in  1  hazard-manager stall request; inserts a bubble into E.
- flush  in  1  squashes the decode-stage instruction.
- jbeq, j, jal, jr  out  1 each  decode-stage control.
- ri, shift, srl  out  1 each  E-stage control.
- alu_op  out  3  E-stage ALU op.
- write_mem  out  1  last-memory-stage store enable.
- write_reg, lw  out  1 each  W-stage control.
- wr_reg_e, lw_e  out  1 each  hazard visibility for E.
- wr_reg_m, lw_m  out  MEM_STAGES each  hazard visibility; bit k-1 is memory stage k.
- hilo_busy  out  1  multiply/divide unit occupied.
- muldiv_stall  out  1  internally generated stall.

Function
REQ-004 Decode SHALL use the following opcode/funct values:
- R-type: opcode 000000.
- BEQ 000100, BNE 000101, J 000010, JAL 000011, LW 100011, SW 101011.
- JR: funct 001000.
- MULT 011000, DIV 011010, MFHI 010000, MFLO 010010.
- SLL funct 000000, SRL funct 000010.
REQ-005 ri SHALL be 1 for every opcode other than R-type, BEQ and BNE.
REQ-006 shift SHALL be 1 for R-type SLL/SRL; srl SHALL be 1 for R-type SRL.
REQ-007 alu_op encoding: 0 ADD/ADDI/LW/SW/default; 1 SUB/BEQ/BNE; 2 AND/ANDI; 3 OR/ORI; 4 XOR/XORI; 5 SLT(101010)/SLTI(001010); 6 NOR(100111).
REQ-008 write_reg SHALL be 0 for BEQ, BNE, SW, J, JAL, JR, MULT and DIV, and 1 otherwise (MFHI/MFLO included).
REQ-009 jbeq SHALL be (BEQ & zero) | (BNE & ~zero).
REQ-010 jbeq, j, jal and jr SHALL be combinational and forced to 0 while flush=1.
REQ-011 bubble = stall | flush | muldiv_stall; on a clk edge with bubble=1, the E register SHALL load all-zero control.
REQ-012 With bubble=0, the E register SHALL load the decoded word.
REQ-013 Memory stages and W SHALL always advance, independent of bubble.
REQ-014 Latency: an instruction decoded at edge t SHALL appear at E at t+1, at memory stage k at t+1+k, and at W at t+2+MEM_STAGES.
REQ-015 write_mem SHALL come from memory stage MEM_STAGES only; write_mem in earlier memory stages is carried but not output.
REQ-016 Busy counter (4 bits): when the E register loads MULT or DIV, the counter SHALL load MULDIV_LAT; otherwise it SHALL decrement if nonzero.
REQ-017 hilo_busy SHALL equal (counter != 0).
REQ-018 muldiv_stall SHALL equal hilo_busy & ~flush & (decode is MULT, DIV, MFHI or MFLO).
REQ-019 Consecutive MULT/DIV: the second SHALL be held in decode until the counter reaches 0, then enter E and reload the counter.
REQ-020 muldiv_stall SHALL not depend on stall, so there is no combinational loop through the hazard manager.
REQ-021 Simultaneous stall and flush SHALL produce a single bubble with decode outputs 0.

Reset
REQ-022 rst=1 at a clk edge SHALL clear E, all memory stages, W and the busy counter; every registered output then reads 0, including hilo_busy and muldiv_stall.
REQ-023 Reset mid-operation (e.g. counter=3) SHALL drop hilo_busy to 0 on the next edge.
REQ-024 Decode outputs SHALL stay combinational during reset.

Verification
REQ-025 LW decoded at edge 0, MEM_STAGES=2 -> lw_e=1 at edge 1; lw_m[0]=1 at edge 2; lw_m[1]=1 at edge 3; lw=1 and write_reg=1 at edge 4.
REQ-026 SW with stall=1 at edge 0 -> E all zero at edge 1; write_mem never asserts for that instruction.
REQ-027 BNE with zero=0 and flush=0 -> jbeq=1; same stimulus with flush=1 -> jbeq=0 and E bubble.
REQ-028 MULT then MFHI back to back, MULDIV_LAT=4 -> hilo_busy=1 for 4 cycles; muldiv_stall=1 for 4 cycles; MFHI enters E on the 5th edge with wr_reg_e=1.
REQ-029 rst asserted while counter=3 and the pipe is full -> next edge: all outputs 0, hilo_busy=0.
REQ-030 XOR R-type (funct 100110) -> alu_op=4, ri=0, shift=0 at E; SLTI -> alu_op=5, ri=1.

Source files
------------

// File: rtl/pipe_ctrl_gen.sv
// pipe_ctrl_gen: control-word generator for a short in-order pipeline.
//
// Decodes the instruction held in the decode stage into control bits, then
// carries those bits down an E / memory (MEM_STAGES deep) / W register chain.
// A 4-bit busy counter tracks multiply/divide occupancy. While that counter is
// nonzero, a HI/LO-related instruction is held in decode.
//
// Parameters:
//   MEM_STAGES  number of memory pipeline stages (1..4)
//   MULDIV_LAT  multiply/divide occupancy in cycles (1..15)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   opcode, funct       decode-stage instruction fields
//   zero                comparator result for the decode-stage branch
//   stall, flush        hazard-manager bubble / squash requests
//   jbeq, j, jal, jr    decode-stage control (combinational, gated by flush)
//   ri, shift, srl      E-stage control
//   alu_op              E-stage ALU operation
//   write_mem           store enable from the last memory stage
//   write_reg, lw       W-stage control
//   wr_reg_e, lw_e      E-stage hazard visibility
//   wr_reg_m, lw_m      memory-stage hazard visibility, bit k-1 = stage k
//   hilo_busy           multiply/divide unit occupied
//   muldiv_stall        internally generated stall for HI/LO instructions
module pipe_ctrl_gen #(
  parameter int MEM_STAGES = 1,
  parameter int MULDIV_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  zero,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  jbeq,
  output logic                  j,
  output logic                  jal,
  output logic                  jr,
  output logic                  ri,
  output logic                  shift,
  output logic                  srl,
  output logic [2:0]            alu_op,
  output logic                  write_mem,
  output logic                  write_reg,
  output logic                  lw,
  output logic                  wr_reg_e,
  output logic                  lw_e,
  output logic [MEM_STAGES-1:0] wr_reg_m,
  output logic [MEM_STAGES-1:0] lw_m,
  output logic                  hilo_busy,
  output logic                  muldiv_stall
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  // Decode-stage classification
  logic       is_r, is_beq, is_bne, is_j, is_jal, is_jr, is_lw, is_sw;
  logic       is_mult, is_div, is_mfhi, is_mflo, is_sll, is_srl;
  logic       d_ri, d_shift, d_srl, d_wm, d_wr, d_lw, d_md, d_hilo;
  logic [2:0] d_alu;

  always_comb begin
    is_r    = (opcode == OP_RTYPE);
    is_beq  = (opcode == OP_BEQ);
    is_bne  = (opcode == OP_BNE);
    is_j    = (opcode == OP_J);
    is_jal  = (opcode == OP_JAL);
    is_lw   = (opcode == OP_LW);
    is_sw   = (opcode == OP_SW);
    is_jr   = is_r && (funct == FN_JR);
    is_mult = is_r && (funct == FN_MULT);
    is_div  = is_r && (funct == FN_DIV);
    is_mfhi = is_r && (funct == FN_MFHI);
    is_mflo = is_r && (funct == FN_MFLO);
    is_sll  = is_r && (funct == FN_SLL);
    is_srl  = is_r && (funct == FN_SRL);

    d_ri    = !(is_r || is_beq || is_bne);
    d_shift = is_sll || is_srl;
    d_srl   = is_srl;
    d_wm    = is_sw;
    d_lw    = is_lw;
    d_wr    = !(is_beq || is_bne || is_sw || is_j || is_jal || is_jr ||
                is_mult || is_div);
    d_md    = is_mult || is_div;
    d_hilo  = is_mult || is_div || is_mfhi || is_mflo;

    d_alu = 3'd0;
    if (is_r) begin
      case (funct)
        FN_SUB:  d_alu = 3'd1;
        FN_AND:  d_alu = 3'd2;
        FN_OR:   d_alu = 3'd3;
        FN_XOR:  d_alu = 3'd4;
        FN_SLT:  d_alu = 3'd5;
        FN_NOR:  d_alu = 3'd6;
        default: d_alu = 3'd0;
      endcase
    end else begin
      case (opcode)
        OP_BEQ, OP_BNE: d_alu = 3'd1;
        OP_ANDI:        d_alu = 3'd2;
        OP_ORI:         d_alu = 3'd3;
        OP_XORI:        d_alu = 3'd4;
        OP_SLTI:        d_alu = 3'd5;
        default:        d_alu = 3'd0;
      endcase
    end
  end

  assign jbeq = !flush && ((is_beq && zero) || (is_bne && !zero));
  assign j    = !flush && is_j;
  assign jal  = !flush && is_jal;
  assign jr   = !flush && is_jr;

  // Pipeline registers
  logic                  e_ri, e_shift, e_srl, e_wm, e_wr, e_lw;
  logic [2:0]            e_alu;
  logic [MEM_STAGES-1:0] m_wm, m_wr, m_lw;
  logic                  w_wr, w_lw;
  logic [3:0]            busy_cnt;
  logic                  bubble;

  // Each chain is {memory stages, E}; top bit is the last memory stage.
  // Shifting by slicing keeps MEM_STAGES=1 legal without a generate split.
  logic [MEM_STAGES:0] wm_chain, wr_chain, lw_chain;
  assign wm_chain = {m_wm, e_wm};
  assign wr_chain = {m_wr, e_wr};
  assign lw_chain = {m_lw, e_lw};

  assign hilo_busy    = (busy_cnt != 4'd0);
  // Independent of stall so no loop forms through the hazard manager.
  assign muldiv_stall = hilo_busy && !flush && d_hilo;
  assign bubble       = stall || flush || muldiv_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      e_ri     <= 1'b0;
      e_shift  <= 1'b0;
      e_srl    <= 1'b0;
      e_alu    <= '0;
      e_wm     <= 1'b0;
      e_wr     <= 1'b0;
      e_lw     <= 1'b0;
      m_wm     <= '0;
      m_wr     <= '0;
      m_lw     <= '0;
      w_wr     <= 1'b0;
      w_lw     <= 1'b0;
      busy_cnt <= '0;
    end else begin
      if (bubble) begin
        e_ri    <= 1'b0;
        e_shift <= 1'b0;
        e_srl   <= 1'b0;
        e_alu   <= '0;
        e_wm    <= 1'b0;
        e_wr    <= 1'b0;
        e_lw    <= 1'b0;
      end else begin
        e_ri    <= d_ri;
        e_shift <= d_shift;
        e_srl   <= d_srl;
        e_alu   <= d_alu;
        e_wm    <= d_wm;
        e_wr    <= d_wr;
        e_lw    <= d_lw;
      end

      m_wm <= wm_chain[MEM_STAGES-1:0];
      m_wr <= wr_chain[MEM_STAGES-1:0];
      m_lw <= lw_chain[MEM_STAGES-1:0];
      w_wr <= wr_chain[MEM_STAGES];
      w_lw <= lw_chain[MEM_STAGES];

      if (!bubble && d_md)
        busy_cnt <= 4'(MULDIV_LAT);
      else if (busy_cnt != 4'd0)
        busy_cnt <= busy_cnt - 4'd1;
    end
  end

  assign ri        = e_ri;
  assign shift     = e_shift;
  assign srl       = e_srl;
  assign alu_op    = e_alu;
  assign wr_reg_e  = e_wr;
  assign lw_e      = e_lw;
  assign wr_reg_m  = m_wr;
  assign lw_m      = m_lw;
  assign write_mem = wm_chain[MEM_STAGES];
  assign write_reg = w_wr;
  assign lw        = w_lw;

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Testbench for pipe_ctrl_gen: directed scenarios followed by randomized
// instruction streams, all checked against a history-based reference model.
module tb_pipe_ctrl_gen;
  localparam int MS  = 2;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst, zero, stall, flush;
  logic [5:0]    opcode, funct;
  logic          jbeq, j, jal, jr, ri, shift, srl, write_mem, write_reg, lw;
  logic          wr_reg_e, lw_e, hilo_busy, muldiv_stall;
  logic [2:0]    alu_op;
  logic [MS-1:0] wr_reg_m, lw_m;

  always #5 clk = ~clk;

  pipe_ctrl_gen #(.MEM_STAGES(MS), .MULDIV_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .stall(stall), .flush(flush), .jbeq(jbeq), .j(j), .jal(jal), .jr(jr),
    .ri(ri), .shift(shift), .srl(srl), .alu_op(alu_op),
    .write_mem(write_mem), .write_reg(write_reg), .lw(lw),
    .wr_reg_e(wr_reg_e), .lw_e(lw_e), .wr_reg_m(wr_reg_m), .lw_m(lw_m),
    .hilo_busy(hilo_busy), .muldiv_stall(muldiv_stall)
  );

  typedef struct packed {
    bit       ri, sh, srl;
    bit [2:0] alu;
    bit       wm, wr, lw;
  } rec_t;

  // hist[0] = E, hist[k] = memory stage k, hist[MS+1] = W
  rec_t hist [0:MS+1];
  int   busy;
  bit   valid = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic string mnem(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      case (fn)
        6'h20: return "ADD";   6'h22: return "SUB";   6'h24: return "AND";
        6'h25: return "OR";    6'h26: return "XOR";   6'h2a: return "SLT";
        6'h27: return "NOR";   6'h08: return "JR";    6'h18: return "MULT";
        6'h1a: return "DIV";   6'h10: return "MFHI";  6'h12: return "MFLO";
        6'h00: return "SLL";   6'h02: return "SRL";
        default: return "RX";
      endcase
    end
    case (op)
      6'h04: return "BEQ";   6'h05: return "BNE";   6'h02: return "J";
      6'h03: return "JAL";   6'h23: return "LW";    6'h2b: return "SW";
      6'h08: return "ADDI";  6'h0c: return "ANDI";  6'h0d: return "ORI";
      6'h0e: return "XORI";  6'h0a: return "SLTI";
      default: return "IX";
    endcase
  endfunction

  function automatic rec_t props(input string m, input logic [5:0] op);
    rec_t r;
    r.ri  = (op != 6'h00) && m != "BEQ" && m != "BNE";
    r.sh  = (m == "SLL") || (m == "SRL");
    r.srl = (m == "SRL");
    if (m == "SUB" || m == "BEQ" || m == "BNE") r.alu = 3'd1;
    else if (m == "AND" || m == "ANDI")         r.alu = 3'd2;
    else if (m == "OR"  || m == "ORI")          r.alu = 3'd3;
    else if (m == "XOR" || m == "XORI")         r.alu = 3'd4;
    else if (m == "SLT" || m == "SLTI")         r.alu = 3'd5;
    else if (m == "NOR")                        r.alu = 3'd6;
    else                                        r.alu = 3'd0;
    r.wm = (m == "SW");
    r.lw = (m == "LW");
    r.wr = !(m == "BEQ" || m == "BNE" || m == "SW" || m == "J" || m == "JAL" ||
             m == "JR" || m == "MULT" || m == "DIV");
    return r;
  endfunction

  function automatic bit hilo_kind(input string m);
    return m == "MULT" || m == "DIV" || m == "MFHI" || m == "MFLO";
  endfunction

  task automatic check_regs(input string m, input bit fl);
    logic [MS-1:0] ew, el;
    for (int k = 0; k < MS; k++) begin
      ew[k] = hist[k+1].wr;
      el[k] = hist[k+1].lw;
    end
    chk("ri",        ri,        hist[0].ri);
    chk("shift",     shift,     hist[0].sh);
    chk("srl",       srl,       hist[0].srl);
    chk("alu_op",    alu_op,    hist[0].alu);
    chk("wr_reg_e",  wr_reg_e,  hist[0].wr);
    chk("lw_e",      lw_e,      hist[0].lw);
    chk("wr_reg_m",  wr_reg_m,  ew);
    chk("lw_m",      lw_m,      el);
    chk("write_mem", write_mem, hist[MS].wm);
    chk("write_reg", write_reg, hist[MS+1].wr);
    chk("lw",        lw,        hist[MS+1].lw);
    chk("hilo_busy", hilo_busy, busy != 0);
    chk("muldiv_stall_post", muldiv_stall, busy != 0 && !fl && hilo_kind(m));
  endtask

  // One clock of stimulus: check decode outputs, advance the model, check stages.
  task automatic step(input bit r, input logic [5:0] op, input logic [5:0] fn,
                      input bit z, input bit st, input bit fl);
    string m;
    bit    exp_ms, bub;
    rst = r; opcode = op; funct = fn; zero = z; stall = st; flush = fl;
    #1;
    m = mnem(op, fn);
    chk("jbeq", jbeq, !fl && ((m == "BEQ" && z) || (m == "BNE" && !z)));
    chk("j",    j,    !fl && m == "J");
    chk("jal",  jal,  !fl && m == "JAL");
    chk("jr",   jr,   !fl && m == "JR");
    exp_ms = valid && busy != 0 && !fl && hilo_kind(m);
    if (valid) begin
      chk("muldiv_stall", muldiv_stall, exp_ms);
      chk("hilo_busy_pre", hilo_busy, busy != 0);
    end
    bub = st || fl || exp_ms;
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i <= MS + 1; i++) hist[i] = '0;
      busy  = 0;
      valid = 1'b1;
    end else if (valid) begin
      for (int i = MS + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = bub ? rec_t'(0) : props(m, op);
      if (!bub && (m == "MULT" || m == "DIV")) busy = LAT;
      else if (busy > 0) busy--;
    end
    if (valid) check_regs(m, fl);
  endtask

  localparam int NT = 25;
  logic [5:0] op_t [NT] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                            6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                            6'h04, 6'h05, 6'h02, 6'h03, 6'h23, 6'h2b, 6'h08,
                            6'h0c, 6'h0d, 6'h0e, 6'h0a};
  logic [5:0] fn_t [NT] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2a, 6'h27,
                            6'h08, 6'h18, 6'h1a, 6'h10, 6'h12, 6'h00, 6'h02,
                            6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                            6'h00, 6'h00, 6'h00, 6'h00};

  localparam logic [5:0] ADD = 6'h20;

  initial begin
    logic [5:0] rop, rfn;
    int         idx;

    // Reset
    step(1, 6'h00, ADD, 0, 0, 0);
    step(1, 6'h00, ADD, 0, 0, 0);
    chk("rst_hilo_busy", hilo_busy, 0);
    chk("rst_muldiv_stall", muldiv_stall, 0);

    // LW walks E -> M1 -> M2 -> W
    step(0, 6'h23, 6'h00, 0, 0, 0);
    chk("lw_e_dir", lw_e, 1);
    step(0, 6'h00, ADD, 0, 0, 0);
    chk("lw_m0_dir", lw_m[0], 1);
    step(0, 6'h00, ADD, 0, 0, 0);
    chk("lw_m1_dir", lw_m[1], 1);
    step(0, 6'h00, ADD, 0, 0, 0);
    chk("lw_w_dir", lw, 1);
    chk("write_reg_w_dir", write_reg, 1);

    // Stalled SW becomes a bubble; write_mem never rises for it
    step(0, 6'h2b, 6'h00, 0, 1, 0);
    chk("sw_stall_e", {ri, shift, srl, alu_op, wr_reg_e, lw_e}, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 6'h00, 6'h25, 0, 0, 0);
      chk("sw_stall_wm", write_mem, 0);
    end

    // BNE taken, then same with flush
    step(0, 6'h05, 6'h00, 0, 0, 0);
    step(0, 6'h05, 6'h00, 0, 0, 1);
    chk("bne_flush_e", {ri, alu_op, wr_reg_e}, 0);
    // Simultaneous stall and flush
    step(0, 6'h02, 6'h00, 0, 1, 1);

    // MULT then MFHI back to back
    step(0, 6'h00, 6'h18, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 6'h00, 6'h10, 0, 0, 0);
      chk("mfhi_held", wr_reg_e, 0);
    end
    chk("mfhi_stall_free", muldiv_stall, 0);
    step(0, 6'h00, 6'h10, 0, 0, 0);
    chk("mfhi_enters", wr_reg_e, 1);

    // Reset with counter at 3 and the pipe full
    step(0, 6'h00, 6'h1a, 0, 0, 0);
    step(0, 6'h23, 6'h00, 0, 0, 0);
    chk("div_busy", hilo_busy, 1);
    step(1, 6'h00, 6'h12, 0, 0, 0);
    chk("rst_mid_busy", hilo_busy, 0);
    chk("rst_mid_pipe", {wr_reg_e, lw_e, wr_reg_m, lw_m, write_reg, lw}, 0);

    // XOR and SLTI
    step(0, 6'h00, 6'h26, 0, 0, 0);
    chk("xor_alu", alu_op, 4);
    chk("xor_ri", ri, 0);
    step(0, 6'h0a, 6'h00, 0, 0, 0);
    chk("slti_alu", alu_op, 5);
    chk("slti_ri", ri, 1);

    // Randomized streams
    for (int n = 0; n < 600; n++) begin
      idx = $urandom_range(0, NT + 1);
      if (idx < NT) begin
        rop = op_t[idx];
        rfn = (rop == 6'h00) ? fn_t[idx] : 6'($urandom);
      end else begin
        rop = 6'($urandom);
        rfn = 6'($urandom);
      end
      step($urandom_range(0, 59) == 0, rop, rfn, 1'($urandom),
           $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
